// File: rtl/frame_packet_arbiter.sv
// rtl/frame_packet_arbiter.sv - two-requester packet arbiter/framer in front of the serial TX buffer
//
// Grants whole packets from the ccd or hk requester and frames each as:
// frameclk pulse, HDR0, HDR1, id[8], id[7:0], payload, XOR checksum.
// Writes are throttled while the TX buffer is full or nearly full.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   ccd_req/valid/data/last/ready    CCD requester and its payload stream
//   hk_req/valid/data/last/ready     housekeeping requester and its payload stream
//   frame_id                         frame number, sampled at grant
//   wrusedw, wrfull                  TX buffer fill level / full flag
//   fifo_data, fifo_wrreq            registered buffer write port
//   frameclk                         one-cycle pulse ahead of each packet
//   grant_src                        0 = ccd, 1 = hk (valid while busy)
//   busy                             packet in progress
//   len_err                          pulse when a packet is cut at MAX_LEN bytes
module frame_packet_arbiter #(
  parameter logic [7:0] HDR0    = 8'hA5,
  parameter logic [7:0] HDR1    = 8'h5A,
  parameter int         DEPTH   = 1024,
  parameter int         MARGIN  = 4,
  parameter int         MAX_LEN = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ccd_req,
  input  logic       ccd_valid,
  input  logic [7:0] ccd_data,
  input  logic       ccd_last,
  output logic       ccd_ready,
  input  logic       hk_req,
  input  logic       hk_valid,
  input  logic [7:0] hk_data,
  input  logic       hk_last,
  output logic       hk_ready,
  input  logic [8:0] frame_id,
  input  logic [9:0] wrusedw,
  input  logic       wrfull,
  output logic [7:0] fifo_data,
  output logic       fifo_wrreq,
  output logic       frameclk,
  output logic       grant_src,
  output logic       busy,
  output logic       len_err
);

  localparam logic [10:0] STALL_LVL = 11'(DEPTH - MARGIN);
  // Count value of the byte that would be the MAX_LEN-th accepted byte.
  localparam logic [9:0]  LAST_CNT  = 10'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FRAME, S_H0, S_H1, S_IDH, S_IDL, S_PAY, S_CHK
  } state_t;

  state_t     state, state_d;
  logic [8:0] id_q;
  logic       src_q;
  logic       prio_q;      // source favoured when both request (0 = ccd)
  logic [9:0] cnt_q;
  logic [7:0] chk_q;

  logic       stall, pay_ready, accept;
  logic       src_valid, src_last;
  logic [7:0] src_data;
  logic       wr_en, grant_now, grant_sel, force_end;
  logic [7:0] wr_byte;

  assign stall     = wrfull | ({1'b0, wrusedw} >= STALL_LVL);
  assign src_valid = src_q ? hk_valid : ccd_valid;
  assign src_data  = src_q ? hk_data  : ccd_data;
  assign src_last  = src_q ? hk_last  : ccd_last;
  assign pay_ready = (state == S_PAY) & ~stall;
  assign accept    = pay_ready & src_valid;
  assign ccd_ready = pay_ready & ~src_q;
  assign hk_ready  = pay_ready & src_q;
  assign frameclk  = (state == S_FRAME);
  assign busy      = (state != S_IDLE);
  assign grant_src = src_q;

  always_comb begin
    state_d   = state;
    wr_en     = 1'b0;
    wr_byte   = 8'h00;
    grant_now = 1'b0;
    grant_sel = 1'b0;
    force_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (ccd_req | hk_req) begin
          grant_now = 1'b1;
          grant_sel = (ccd_req & hk_req) ? prio_q : hk_req;
          state_d   = S_FRAME;
        end
      end
      S_FRAME: state_d = S_H0;
      S_H0: if (!stall) begin wr_en = 1'b1; wr_byte = HDR0;              state_d = S_H1;  end
      S_H1: if (!stall) begin wr_en = 1'b1; wr_byte = HDR1;              state_d = S_IDH; end
      S_IDH: if (!stall) begin wr_en = 1'b1; wr_byte = {7'b0, id_q[8]}; state_d = S_IDL; end
      S_IDL: if (!stall) begin wr_en = 1'b1; wr_byte = id_q[7:0];       state_d = S_PAY; end
      S_PAY: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_byte = src_data;
          if (src_last) begin
            state_d = S_CHK;
          end else if (cnt_q == LAST_CNT) begin
            // Packet hit its length cap without a last marker: cut it here.
            force_end = 1'b1;
            state_d   = S_CHK;
          end
        end
      end
      S_CHK: if (!stall) begin wr_en = 1'b1; wr_byte = chk_q; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      id_q       <= '0;
      src_q      <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      chk_q      <= '0;
      fifo_data  <= '0;
      fifo_wrreq <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_d;
      fifo_wrreq <= wr_en;
      fifo_data  <= wr_byte;
      len_err    <= force_end;
      if (grant_now) begin
        id_q  <= frame_id;
        src_q <= grant_sel;
        cnt_q <= '0;
        // Checksum starts from the two id bytes; header bytes are excluded.
        chk_q <= {7'b0, frame_id[8]} ^ frame_id[7:0];
      end else if (accept) begin
        cnt_q <= cnt_q + 10'd1;
        chk_q <= chk_q ^ src_data;
      end
      if (state == S_CHK && !stall) prio_q <= ~src_q;
    end
  end

endmodule

// File: tb/tb_frame_packet_arbiter.sv
// tb/tb_frame_packet_arbiter.sv - self-checking bench for frame_packet_arbiter
module tb_frame_packet_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ccd_req, ccd_valid, ccd_last, ccd_ready;
  logic [7:0] ccd_data;
  logic       hk_req, hk_valid, hk_last, hk_ready;
  logic [7:0] hk_data;
  logic [8:0] frame_id;
  logic [9:0] wrusedw;
  logic       wrfull;
  logic [7:0] fifo_data;
  logic       fifo_wrreq, frameclk, grant_src, busy, len_err;

  always #10 clk = ~clk;

  frame_packet_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ccd_req(ccd_req), .ccd_valid(ccd_valid), .ccd_data(ccd_data), .ccd_last(ccd_last), .ccd_ready(ccd_ready),
    .hk_req(hk_req), .hk_valid(hk_valid), .hk_data(hk_data), .hk_last(hk_last), .hk_ready(hk_ready),
    .frame_id(frame_id), .wrusedw(wrusedw), .wrfull(wrfull),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .frameclk(frameclk),
    .grant_src(grant_src), .busy(busy), .len_err(len_err)
  );

  localparam int MAXL = 1023;

  typedef struct {
    bit         src;
    logic [8:0] id;
    int         n;
    bit         term_last;
    int         gap;
    int         step;
    int         smode;
    int         exp_wr;
    int         exp_le;
  } vec_t;

  vec_t       vecs[7];
  int         total = 0, bad = 0;
  int         cyc = 0, fc_cyc = -100, fc_n = 0, le_n = 0;
  bit         prev_stall = 1'b0;
  int         stall_mode = 0;
  int         sd;
  logic [7:0] got[$], exp_q[$], sv3[$];
  int         wr_cyc[$];
  logic       gnt_q[$];
  logic [7:0] pay[0:1199];

  // Sink monitor: collects buffer writes and pulses, and flags any write
  // that follows a cycle in which the buffer reported stall.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_wrreq) begin
      got.push_back(fifo_data);
      wr_cyc.push_back(cyc);
      total++;
      if (prev_stall) begin
        bad++;
        $display("FAIL wr_after_stall: wrreq=1 at cycle %0d, required 0", cyc);
      end
    end
    if (frameclk) begin
      fc_n++;
      fc_cyc = cyc;
      gnt_q.push_back(grant_src);
    end
    if (len_err) le_n++;
    prev_stall = wrfull || (wrusedw >= 10'd1020);
  end

  // Buffer-level driver: 0 = empty, 1 = random fill, 2 = stall exactly the H1 slot for 5 cycles.
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0: begin wrusedw = 10'd0; wrfull = 1'b0; end
      1: begin
        wrusedw = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1020, 1023)) : 10'($urandom_range(0, 1019));
        wrfull  = ($urandom_range(0, 15) == 0);
      end
      default: begin
        sd = cyc - fc_cyc;
        wrusedw = (sd >= 1 && sd <= 5) ? 10'd1020 : 10'd1019;
        wrfull  = 1'b0;
      end
    endcase
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] a[$], input logic [7:0] b[$]);
    int first_bad;
    first_bad = -1;
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (first_bad < 0 && a[i] !== b[i]) first_bad = i;
    total++;
    if (a.size() != b.size() || first_bad >= 0) begin
      bad++;
      if (first_bad >= 0)
        $display("FAIL %s: byte %0d got %02h expected %02h (sizes %0d/%0d)", name, first_bad, a[first_bad], b[first_bad], a.size(), b.size());
      else
        $display("FAIL %s: got %0d bytes expected %0d", name, a.size(), b.size());
    end
  endtask

  task automatic clr_mon();
    got.delete(); wr_cyc.delete(); gnt_q.delete();
    fc_n = 0; le_n = 0; fc_cyc = -100;
  endtask

  // Reference framing: header, id bytes, first m payload bytes, XOR of id and payload.
  task automatic add_pkt(input logic [8:0] id, input int m);
    logic [7:0] x;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back({7'b0, id[8]});
    exp_q.push_back(id[7:0]);
    x = {7'b0, id[8]} ^ id[7:0];
    for (int i = 0; i < m; i++) begin
      exp_q.push_back(pay[i]);
      x = x ^ pay[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic set_src(input bit src, input bit v, input logic [7:0] d, input bit l);
    if (src) begin hk_valid = v; hk_data = d; hk_last = l; end
    else     begin ccd_valid = v; ccd_data = d; ccd_last = l; end
  endtask

  task automatic run_pkt(input bit src, input logic [8:0] id, input int n, input bit term_last,
                         input int gap, output int acc);
    int idx, cnt;
    bit seen_busy;
    clr_mon();
    acc = 0; idx = 0; seen_busy = 0;
    @(posedge clk); #1;
    frame_id = id;
    if (src) hk_req = 1'b1; else ccd_req = 1'b1;
    for (cnt = 0; cnt < 6000; cnt++) begin
      @(negedge clk);
      if (src ? (hk_valid && hk_ready) : (ccd_valid && ccd_ready)) begin acc++; idx++; end
      if (busy) seen_busy = 1;
      if (seen_busy && !busy) break;
      @(posedge clk); #1;
      if (seen_busy) begin ccd_req = 1'b0; hk_req = 1'b0; end
      if (seen_busy && idx < n && (cnt % gap) == 0) set_src(src, 1'b1, pay[idx], term_last && idx == n - 1);
      else set_src(src, 1'b0, 8'h00, 1'b0);
    end
    chk("pkt_done_in_budget", int'(cnt < 6000), 1);
    @(posedge clk); #1;
    ccd_req = 1'b0; hk_req = 1'b0;
    set_src(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_pkt(input bit src, input logic [8:0] id, input int n, input bit term_last,
                           input int exp_wr, input int exp_le, input int acc, input int smode);
    int m;
    m = (term_last && n <= MAXL) ? n : MAXL;
    exp_q.delete();
    add_pkt(id, m);
    chk("wr_count", got.size(), exp_wr);
    check_seq("bytes", got, exp_q);
    chk("accepted", acc, m);
    chk("frameclk_pulses", fc_n, 1);
    chk("len_err_pulses", le_n, exp_le);
    chk("grant_src", (gnt_q.size() == 1) ? int'(gnt_q[0]) : -1, int'(src));
    if (got.size() > 1) begin
      if (smode == 0) chk("h0_latency", wr_cyc[0] - fc_cyc, 2);
      if (smode == 2) chk("h1_stall_latency", wr_cyc[1] - fc_cyc, 8);
    end
  endtask

  initial begin
    int acc, n, gap;
    bit src, e;
    logic [8:0] id;
    logic [7:0] ref0[$];

    vecs[0] = '{1'b0, 9'h12F, 3,    1'b1, 1, 1,  0, 8,    0};
    vecs[1] = '{1'b1, 9'h0FF, 1,    1'b1, 1, 3,  0, 6,    0};
    vecs[2] = '{1'b0, 9'h100, 20,   1'b1, 1, 7,  1, 25,   0};
    vecs[3] = '{1'b1, 9'h055, 12,   1'b1, 3, 5,  0, 17,   0};
    vecs[4] = '{1'b1, 9'h1AA, 1100, 1'b0, 1, 11, 0, 1028, 1};
    vecs[5] = '{1'b0, 9'h003, 1023, 1'b1, 1, 13, 0, 1028, 0};
    vecs[6] = '{1'b0, 9'h1FF, 8,    1'b1, 1, 9,  2, 13,   0};

    rst_n = 1'b0;
    ccd_req = 0; ccd_valid = 0; ccd_data = 0; ccd_last = 0;
    hk_req = 0; hk_valid = 0; hk_data = 0; hk_last = 0;
    frame_id = 0; wrusedw = 0; wrfull = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({fifo_wrreq, fifo_data, frameclk, grant_src, busy, len_err, ccd_ready, hk_ready}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesting from reset: expect ccd, hk, ccd.
    clr_mon();
    frame_id = 9'h0A0;
    ccd_req = 1; hk_req = 1;
    ccd_valid = 1; ccd_data = 8'hC1; ccd_last = 1;
    hk_valid = 1;  hk_data = 8'h4B;  hk_last = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (fc_n >= 3 && !busy) break;
      @(posedge clk); #1;
      if (fc_n >= 3) begin ccd_req = 0; hk_req = 0; end
    end
    @(posedge clk); #1;
    ccd_valid = 0; hk_valid = 0; ccd_req = 0; hk_req = 0;
    exp_q.delete();
    e = 1'b0;
    chk("arb_grants", gnt_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < gnt_q.size()) chk("arb_order", int'(gnt_q[k]), int'(e));
      pay[0] = e ? 8'h4B : 8'hC1;
      add_pkt(9'h0A0, 1);
      e = ~e;
    end
    check_seq("arb_bytes", got, exp_q);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) pay[i] = 8'(i * vecs[v].step + 1);
      stall_mode = vecs[v].smode;
      run_pkt(vecs[v].src, vecs[v].id, vecs[v].n, vecs[v].term_last, vecs[v].gap, acc);
      stall_mode = 0;
      check_pkt(vecs[v].src, vecs[v].id, vecs[v].n, vecs[v].term_last, vecs[v].exp_wr, vecs[v].exp_le, acc, vecs[v].smode);
      if (v == 0) begin
        ref0 = '{8'hA5, 8'h5A, 8'h01, 8'h2F, 8'h01, 8'h02, 8'h03, 8'h2E};
        check_seq("first_packet_literal", got, ref0);
      end
      if (v == 3) sv3 = got;
    end

    for (int r = 0; r < 6; r++) begin
      src = 1'($urandom_range(0, 1));
      id  = 9'($urandom_range(0, 511));
      n   = $urandom_range(1, 40);
      gap = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      stall_mode = 1;
      run_pkt(src, id, n, 1'b1, gap, acc);
      stall_mode = 0;
      check_pkt(src, id, n, 1'b1, n + 5, 0, acc, 1);
    end

    // Same hk payload as the gapped vector, now gap-free: identical byte stream.
    for (int i = 0; i < 12; i++) pay[i] = 8'(i * 5 + 1);
    run_pkt(1'b1, 9'h055, 12, 1'b1, 1, acc);
    check_pkt(1'b1, 9'h055, 12, 1'b1, 17, 0, acc, 0);
    check_seq("gap_vs_nogap", got, sv3);

    // ccd packet so the round-robin pointer favours hk before the reset test.
    pay[0] = 8'h99;
    run_pkt(1'b0, 9'h021, 1, 1'b1, 1, acc);
    check_pkt(1'b0, 9'h021, 1, 1'b1, 6, 0, acc, 0);

    // Reset in the middle of an hk payload.
    clr_mon();
    @(posedge clk); #1;
    frame_id = 9'h1C3; hk_req = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (got.size() >= 6) break;
      @(posedge clk); #1;
      if (busy) begin hk_req = 0; hk_valid = 1; hk_data = 8'h77; hk_last = 0; end
    end
    chk("mid_payload_reached", int'(got.size() >= 6), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; hk_valid = 0; hk_req = 0;
    @(negedge clk);
    chk("reset_mid_outputs", int'({fifo_wrreq, fifo_data, frameclk, grant_src, busy, len_err, ccd_ready, hk_ready}), 0);

    // After reset both request together: ccd must win, packet restarts cleanly.
    clr_mon();
    @(posedge clk); #1;
    frame_id = 9'h0E7;
    ccd_req = 1; hk_req = 1;
    ccd_valid = 1; ccd_data = 8'h3C; ccd_last = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (fc_n >= 1 && !busy) break;
      @(posedge clk); #1;
      if (fc_n >= 1) begin ccd_req = 0; hk_req = 0; end
    end
    @(posedge clk); #1;
    ccd_valid = 0; ccd_req = 0; hk_req = 0;
    chk("post_reset_grant", (gnt_q.size() >= 1) ? int'(gnt_q[0]) : -1, 0);
    chk("post_reset_frameclk", fc_n, 1);
    exp_q.delete();
    pay[0] = 8'h3C;
    add_pkt(9'h0E7, 1);
    check_seq("post_reset_bytes", got, exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_packet_arbiter.md
Name: frame_packet_arbiter

Overview:
- Shares the single serial-send TX buffer write port between two packet requesters: the CCD pixel stream (ccd) and a housekeeping/status source (hk).
- Grants whole packets and frames each one as: frameclk pulse, header 0xA5 0x5A, 2-byte frame id, payload, XOR checksum.
- Throttles on buffer fill level.
- Sits between the CCD/ADC capture logic and the serial-send buffer, replacing the direct data/wrclk/wrreq/frameclk connection.

Parameters:
- HDR0, 8'hA5, first header byte
- HDR1, 8'h5A, second header byte
- DEPTH, 1024, TX buffer depth in bytes
- MARGIN, 4, writes stall while wrusedw >= DEPTH-MARGIN
- MAX_LEN, 1023, maximum payload bytes per packet before forced termination

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- ccd_req  in  1  CCD requester has a packet pending
- ccd_valid  in  1  ccd_data valid
- ccd_data  in  8  CCD payload byte
- ccd_last  in  1  marks final payload byte (qualified by ccd_valid)
- ccd_ready  out  1  CCD byte accepted this cycle when valid&ready
- hk_req, hk_valid, hk_data[7:0], hk_last, hk_ready: same as the ccd_* set, for the housekeeping requester
- frame_id  in  9  frame number, sampled at grant
- wrusedw  in  10  buffer fill count
- wrfull  in  1  buffer full
- fifo_data  out  8  byte to buffer, registered
- fifo_wrreq  out  1  write strobe, registered, one byte per high cycle
- frameclk  out  1  one-cycle pulse preceding each packet's first write
- grant_src  out  1  0 = ccd, 1 = hk; valid while busy
- busy  out  1  packet in progress
- len_err  out  1  one-cycle pulse on MAX_LEN forced termination

Behaviour:
- Reset (synchronous, rst_n low at a clk edge): all outputs 0, state IDLE, round-robin pointer favours ccd, byte counter and checksum cleared.
  - Reset mid-packet abandons the packet with no checksum written.
- stall = wrfull | (wrusedw >= DEPTH-MARGIN).
- FSM states: IDLE, FRAME, H0, H1, IDH, IDL, PAY, CHK.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the source not granted last (round-robin); the first after reset goes to ccd.
  - On grant: latch frame_id and grant_src, set busy=1, go to FRAME.
- FRAME: frameclk=1 for exactly this one cycle, no write, next state H0.
- Header states advance only when !stall:
  - H0 writes HDR0, then H1.
  - H1 writes HDR1, then IDH.
  - IDH writes {7'b0, id[8]}, then IDL.
  - IDL writes id[7:0], then PAY.
  - On a stalled cycle: no write, state holds.
- Write timing: a byte "written" in state S at cycle n appears as fifo_wrreq=1 / fifo_data at cycle n+1 (1-cycle latency).
- PAY:
  - Granted source's ready = !stall; the other source's ready = 0 always.
  - On valid&ready: forward the byte, increment counter, XOR into checksum.
  - If last is set on that byte, go to CHK.
  - If the counter reaches MAX_LEN without last: ready drops, len_err pulses, go to CHK. Following source bytes are not consumed by this packet.
- CHK: when !stall, write the checksum, clear busy, toggle the round-robin pointer, return to IDLE.
  - Checksum = XOR of the two id bytes and all payload bytes; header bytes excluded.
- Empty packet is impossible: the first payload byte is always required; a valid-less source simply holds PAY.
- req is sampled only in IDLE; deasserting req mid-packet has no effect. Only last ends a packet.
- Minimum gap between packets: 1 IDLE cycle after CHK.
- fifo_wrreq is never asserted on a cycle following a stalled decision. Byte written count per packet = 4 + N + 1.

Test Plan:
- ccd_req only, frame_id=9'h12F, payload 0x01,0x02,0x03(last), no stall -> frameclk 1 cycle, then writes A5 5A 01 2F 01 02 03 2E; busy low after checksum.
- ccd_req and hk_req high together from reset, 1-byte packets each -> ccd packet first, then hk; grant_src 0 then 1; next simultaneous request goes to ccd again.
- wrusedw=1020 during H1 for 5 cycles -> no fifo_wrreq in those cycles, H1 byte 5A written once after wrusedw drops to 1019, no duplicates.
- hk stream of 1100 bytes without last -> exactly 1023 payload bytes accepted, len_err pulses once, checksum written, hk_ready 0 afterwards until next grant.
- rst_n low for 1 cycle mid-payload -> next cycle all outputs 0, state IDLE; new request restarts with frameclk and A5.
- Payload with hk_valid gaps (valid every 3rd cycle) -> output byte sequence identical to the gap-free case, fifo_wrreq only on accepted bytes.
